// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: opcodes, exception codes, stored result entry and FIFO states.
package alu_result_stage_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  // Register that receives the exception code on overflow.
  localparam logic [4:0] RSTATUS_REG = 5'd30;

  localparam logic [31:0] EXC_ADD  = 32'd1;
  localparam logic [31:0] EXC_ADDI = 32'd2;
  localparam logic [31:0] EXC_SUB  = 32'd3;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic        ne;
    logic        lt;
  } entry_t;

  // FIFO occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    FifoEmpty = 2'd0,
    FifoOne   = 2'd1,
    FifoFull  = 2'd2
  } fifo_state_e;

  // Build the entry that will be stored for one accepted ALU result.
  function automatic entry_t remap_result(input logic [31:0] result,
                                          input logic [4:0]  opcode,
                                          input logic        is_imm,
                                          input logic [4:0]  rd,
                                          input logic        overflow,
                                          input logic        ne,
                                          input logic        lt);
    entry_t e;
    e.ne = ne;
    e.lt = lt;
    if (overflow && (opcode == OP_ADD || opcode == OP_SUB)) begin
      // Exceptions always target r30, even when rd was r0.
      if (opcode == OP_SUB) begin
        e.data = EXC_SUB;
      end else if (is_imm) begin
        e.data = EXC_ADDI;
      end else begin
        e.data = EXC_ADD;
      end
      e.rd  = RSTATUS_REG;
      e.we  = 1'b1;
      e.exc = 1'b1;
    end else begin
      e.data = result;
      e.rd   = rd;
      e.we   = (rd != 5'd0);
      e.exc  = 1'b0;
    end
    return e;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between ALU (upstream), result stage and writeback (downstream).
interface alu_result_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_opcode;
  logic        in_is_imm;
  logic [4:0]  in_rd;
  logic        in_overflow;
  logic        in_ne;
  logic        in_lt;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_ne;
  logic        out_lt;
  logic        out_exc;

  // Environment side: drives ALU results and writeback ready.
  modport master (
    output in_valid, in_result, in_opcode, in_is_imm, in_rd, in_overflow, in_ne, in_lt,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_rd, out_we, out_ne, out_lt, out_exc
  );

  // Result stage side.
  modport slave (
    input  in_valid, in_result, in_opcode, in_is_imm, in_rd, in_overflow, in_ne, in_lt,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_rd, out_we, out_ne, out_lt, out_exc
  );

endinterface

// File: rtl/alu_result_stage_result_fifo2.sv
// Generic two-entry valid/ready FIFO; in_ready is registered so there is no
// combinational path from out_ready back to the producer.
module result_fifo2
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  fifo_state_e      state_q, state_d;
  logic             head_q, tail_q;
  logic             in_ready_q;
  logic [WIDTH-1:0] mem_q [2];
  logic             push, pop;

  assign push      = in_valid && in_ready_q;
  assign pop       = (state_q != FifoEmpty) && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != FifoEmpty);
  // Idle outputs are forced to zero rather than showing stale storage.
  assign out_data  = out_valid ? mem_q[head_q] : '0;

  // Next occupancy state from push/pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FifoEmpty: if (push) state_d = FifoOne;
      FifoOne: begin
        if (push && !pop) begin
          state_d = FifoFull;
        end else if (!push && pop) begin
          state_d = FifoEmpty;
        end
      end
      FifoFull:  if (pop) state_d = FifoOne;
      default:   state_d = FifoEmpty;
    endcase
  end

  // State, pointers, registered ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FifoEmpty;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (32'(state_d) != DEPTH);
      if (pop)  head_q <= head_q + 1'b1;
      if (push) tail_q <= tail_q + 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[tail_q] <= in_data;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: overflow-exception remap, r0 write suppression, 2-deep skid
// FIFO toward writeback, and a saturating overflow-event counter.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  alu_result_stage_if.slave  bus,
  output logic [CNT_W-1:0]   ovf_count
);

  entry_t           acc_entry;
  entry_t           head_entry;
  logic             fifo_in_ready;
  logic             fifo_out_valid;
  logic             accept;
  logic [CNT_W-1:0] ovf_count_q;

  assign acc_entry = remap_result(bus.in_result, bus.in_opcode, bus.in_is_imm, bus.in_rd,
                                  bus.in_overflow, bus.in_ne, bus.in_lt);
  assign accept    = bus.in_valid && fifo_in_ready;

  result_fifo2 #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (acc_entry),
    .out_valid (fifo_out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head_entry)
  );

  assign bus.in_ready  = fifo_in_ready;
  assign bus.out_valid = fifo_out_valid;
  assign bus.out_data  = head_entry.data;
  assign bus.out_rd    = head_entry.rd;
  assign bus.out_we    = head_entry.we;
  assign bus.out_exc   = head_entry.exc;
  assign bus.out_ne    = head_entry.ne;
  assign bus.out_lt    = head_entry.lt;
  assign ovf_count     = ovf_count_q;

  // Count accepted exceptions, holding at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_count_q <= '0;
    end else if (accept && acc_entry.exc && (ovf_count_q != {CNT_W{1'b1}})) begin
      ovf_count_q <= ovf_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: vector table, back-pressure,
// random throughput, reset and counter saturation, against a queue model.
module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ovf_count;

  alu_result_stage_if bus ();

  alu_result_stage #(
    .DEPTH (2),
    .CNT_W (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .ovf_count (ovf_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  op;
    logic        imm;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ovf;
    logic        ne;
    logic        lt;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_we;
    logic        e_exc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic        ne;
    logic        lt;
  } exp_t;

  exp_t        q[$];
  int unsigned model_cnt;
  int          n_cmp;
  int          n_fail;
  vec_t        vecs[8];

  // Reference: what writeback must see for one ALU result.
  function automatic exp_t model(input logic [4:0] op, input logic imm, input logic [31:0] res,
                                 input logic [4:0] rd, input logic ovf, input logic ne,
                                 input logic lt);
    exp_t e;
    e.ne = ne;
    e.lt = lt;
    if (ovf && (op == 5'd0 || op == 5'd1)) begin
      e.data = (op == 5'd1) ? 32'd3 : (imm ? 32'd2 : 32'd1);
      e.rd   = 5'd30;
      e.we   = 1'b1;
      e.exc  = 1'b1;
    end else begin
      e.data = res;
      e.rd   = rd;
      e.we   = (rd != 5'd0);
      e.exc  = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic imm, input logic [31:0] res,
                       input logic [4:0] rd, input logic ovf, input logic ne, input logic lt);
    bus.in_valid    = 1'b1;
    bus.in_opcode   = op;
    bus.in_is_imm   = imm;
    bus.in_result   = res;
    bus.in_rd       = rd;
    bus.in_overflow = ovf;
    bus.in_ne       = ne;
    bus.in_lt       = lt;
  endtask

  task automatic idle_in();
    drive(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
  endtask

  // Called at a negedge: score the head, record any accept, advance one cycle.
  task automatic step();
    exp_t e;
    chk("ovf_count", {24'd0, ovf_count}, model_cnt);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb_data", bus.out_data, e.data);
        chk("sb_rd",   {27'd0, bus.out_rd}, {27'd0, e.rd});
        chk("sb_we_exc_ne_lt", {28'd0, bus.out_we, bus.out_exc, bus.out_ne, bus.out_lt},
            {28'd0, e.we, e.exc, e.ne, e.lt});
      end
    end else if (!bus.out_valid) begin
      chk("idle_zero", bus.out_data, 32'd0);
    end
    if (bus.in_valid && bus.in_ready) begin
      e = model(bus.in_opcode, bus.in_is_imm, bus.in_result, bus.in_rd, bus.in_overflow,
                bus.in_ne, bus.in_lt);
      q.push_back(e);
      if (e.exc && model_cnt < 255) model_cnt++;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ecnt;
    logic [31:0] held;
    n_cmp     = 0;
    n_fail    = 0;
    model_cnt = 0;
    reset     = 1'b1;
    bus.out_ready = 1'b0;
    idle_in();

    vecs[0] = '{OP_ADD, 1'b0, 32'h0000_0005, 5'd7,  1'b0, 1'b0, 1'b0, 32'h5,  5'd7,  1'b1, 1'b0};
    vecs[1] = '{OP_ADD, 1'b1, 32'h1234_5678, 5'd4,  1'b1, 1'b0, 1'b0, 32'h2,  5'd30, 1'b1, 1'b1};
    vecs[2] = '{OP_SUB, 1'b0, 32'h8000_0000, 5'd9,  1'b1, 1'b1, 1'b0, 32'h3,  5'd30, 1'b1, 1'b1};
    vecs[3] = '{OP_SLL, 1'b0, 32'h0000_0080, 5'd3,  1'b1, 1'b0, 1'b0, 32'h80, 5'd3,  1'b1, 1'b0};
    vecs[4] = '{OP_OR,  1'b0, 32'hFFFF_FFFF, 5'd0,  1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd0, 1'b0,
                1'b0};
    vecs[5] = '{OP_ADD, 1'b0, 32'h7FFF_FFFF, 5'd0,  1'b1, 1'b0, 1'b1, 32'h1,  5'd30, 1'b1, 1'b1};
    vecs[6] = '{OP_AND, 1'b0, 32'h0000_0F0F, 5'd31, 1'b1, 1'b1, 1'b1, 32'hF0F, 5'd31, 1'b1, 1'b0};
    vecs[7] = '{OP_SUB, 1'b1, 32'h0000_DEAD, 5'd1,  1'b0, 1'b0, 1'b1, 32'hDEAD, 5'd1, 1'b1, 1'b0};

    // Reset values.
    @(negedge clock);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_data",  bus.out_data, 32'd0);
    chk("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Vector table: one result at a time, visible the cycle after accept.
    ecnt = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].imm, vecs[i].res, vecs[i].rd, vecs[i].ovf, vecs[i].ne,
            vecs[i].lt);
      step();
      idle_in();
      if (vecs[i].e_exc) ecnt++;
      chk("vec_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("vec_data",  bus.out_data, vecs[i].e_data);
      chk("vec_rd",    {27'd0, bus.out_rd}, {27'd0, vecs[i].e_rd});
      chk("vec_we",    {31'd0, bus.out_we}, {31'd0, vecs[i].e_we});
      chk("vec_exc",   {31'd0, bus.out_exc}, {31'd0, vecs[i].e_exc});
      chk("vec_flags", {30'd0, bus.out_ne, bus.out_lt}, {30'd0, vecs[i].ne, vecs[i].lt});
      chk("vec_ovf",   {24'd0, ovf_count}, ecnt);
      step();
    end

    // Back-pressure: A, B fill the FIFO, C stalls, then all drain in order.
    bus.out_ready = 1'b0;
    drive(OP_ADD, 1'b0, 32'hAAAA_0001, 5'd11, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_ready_after_A", {31'd0, bus.in_ready}, 32'd1);
    drive(OP_OR, 1'b0, 32'hBBBB_0002, 5'd12, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_ready_after_B", {31'd0, bus.in_ready}, 32'd0);
    drive(OP_SRA, 1'b0, 32'hCCCC_0003, 5'd13, 1'b0, 1'b0, 1'b1);
    held = bus.out_data;
    chk("bp_head_A", held, 32'hAAAA_0001);
    step();
    chk("bp_still_full", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("bp_head_held", bus.out_data, 32'hAAAA_0001);
    chk("bp_rd_held",   {27'd0, bus.out_rd}, 32'd11);
    chk("bp_queue_len", q.size(), 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic acc;
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) idle_in();
    end
    chk("bp_drained", q.size(), 32'd0);
    chk("bp_c_taken", {31'd0, bus.in_valid}, 32'd0);

    // Sustained random stream: one per cycle, never back-pressured.
    for (int i = 0; i < 100; i++) begin
      drive(5'($urandom_range(0, 5)), 1'($urandom), $urandom, 5'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      chk("thru_in_ready", {31'd0, bus.in_ready}, 32'd1);
      if (i > 0) chk("thru_out_valid", {31'd0, bus.out_valid}, 32'd1);
      step();
    end
    idle_in();
    step();
    step();
    chk("thru_drained", q.size(), 32'd0);

    // Reset while full.
    bus.out_ready = 1'b0;
    drive(OP_SUB, 1'b0, 32'h1, 5'd2, 1'b1, 1'b1, 1'b1);
    step();
    drive(OP_AND, 1'b0, 32'h5555_5555, 5'd6, 1'b0, 1'b1, 1'b1);
    step();
    idle_in();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_data_rd",   {bus.out_data[26:0], bus.out_rd}, 32'd0);
    chk("mid_rst_bits",      {28'd0, bus.out_we, bus.out_exc, bus.out_ne, bus.out_lt}, 32'd0);
    chk("mid_rst_ovf",       {24'd0, ovf_count}, 32'd0);
    q.delete();
    model_cnt = 0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    bus.out_ready = 1'b1;
    drive(OP_ADD, 1'b0, 32'h0000_0077, 5'd5, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("post_rst_data",  bus.out_data, 32'h77);
    step();
    chk("post_rst_empty", {31'd0, bus.out_valid}, 32'd0);

    // 300 exceptions saturate the 8-bit counter.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 1) == 0) ? OP_ADD : OP_SUB, 1'($urandom), $urandom, 5'($urandom),
            1'b1, 1'b0, 1'b0);
      step();
    end
    idle_in();
    step();
    chk("ovf_saturated", {24'd0, ovf_count}, 32'd255);
    chk("sat_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
